// File: rtl/matrix_load_arbiter_pkg.sv
// Shared constants, FSM state type and index-width helper for the matrix load arbiter.
package matrix_pkg;

    localparam int   MAT_W     = 256;
    localparam logic MEM_LATCH = 1'b0;
    localparam logic MEM_LOAD  = 1'b1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOAD = 1'b1
    } arb_state_t;

    // Index width for a count of items; never narrower than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/matrix_load_arbiter_if.sv
// Requester/bank-side bundle of the matrix load arbiter; slave = arbiter, master = requesters and banks.
interface matrix_load_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_BANK = 4,
    parameter int MAT_W    = matrix_pkg::MAT_W
);
    localparam int BW = matrix_pkg::clog2(NUM_BANK);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*BW-1:0]    req_bank;
    logic [NUM_REQ*MAT_W-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_BANK-1:0]      mem_state;
    logic [MAT_W-1:0]         mem_din;
    logic [NUM_BANK-1:0]      bank_full;
    logic [NUM_BANK-1:0]      bank_release;
    logic                     busy;

    modport slave (
        input  req_valid, req_bank, req_data, bank_release,
        output req_ready, mem_state, mem_din, bank_full, busy
    );

    modport master (
        output req_valid, req_bank, req_data, bank_release,
        input  req_ready, mem_state, mem_din, bank_full, busy
    );

endinterface

// File: rtl/matrix_load_arbiter_rr_picker.sv
// Combinational picker: first set bit of elig at or after ptr, wrapping modulo NUM_REQ.
module rr_picker
    import matrix_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int RW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [RW-1:0]      ptr,
    output logic [RW-1:0]      winner,
    output logic               found
);

    logic [RW-1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = RW'((int'(ptr) + k) % NUM_REQ);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/matrix_load_arbiter.sv
// Round-robin arbiter sharing NUM_BANK matrix registers among NUM_REQ loaders, with per-bank full tracking.
// Define MATRIX_ARB_FIXED_PRIO_EN for fixed priority (lowest requester index wins).
module matrix_load_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_BANK = 4,
    parameter int MAT_W    = matrix_pkg::MAT_W
) (
    input logic                  CLK,
    input logic                  reset,
    matrix_load_arbiter_if.slave bus
);
    import matrix_pkg::*;

    localparam int BW = clog2(NUM_BANK);
    localparam int RW = clog2(NUM_REQ);

    arb_state_t          state, state_nx;
    logic [NUM_REQ-1:0]  ready_q, ready_nx;
    logic [NUM_BANK-1:0] mstate_q, mstate_nx;
    logic [NUM_BANK-1:0] full_q, full_nx;
    logic [MAT_W-1:0]    din_q, din_nx;
    logic [RW-1:0]       cur_q, cur_nx;
    logic [RW-1:0]       win, pick_ptr;
    logic [BW-1:0]       win_bank;
    logic [NUM_REQ-1:0]  elig;
    logic                found;

    // The requester being loaded this cycle is masked so it cannot win twice for one request.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = bus.req_valid[i]
                   && !full_q[bus.req_bank[i*BW +: BW]]
                   && !(state == ARB_LOAD && cur_q == RW'(i));
        end
    end

    rr_picker #(.NUM_REQ(NUM_REQ), .RW(RW)) u_picker (
        .elig   (elig),
        .ptr    (pick_ptr),
        .winner (win),
        .found  (found)
    );

    assign win_bank = bus.req_bank[win*BW +: BW];

`ifdef MATRIX_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [RW-1:0] rr_ptr;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= (win == RW'(NUM_REQ - 1)) ? '0 : win + RW'(1);
        end
    end

    assign pick_ptr = rr_ptr;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        ready_nx  = '0;
        mstate_nx = {NUM_BANK{MEM_LATCH}};
        din_nx    = din_q;
        cur_nx    = cur_q;
        full_nx   = full_q & ~bus.bank_release;

        case (state)
            ARB_IDLE: if (found)  state_nx = ARB_LOAD;
            ARB_LOAD: if (!found) state_nx = ARB_IDLE;
            default:              state_nx = ARB_IDLE;
        endcase

        // A grant's set is applied after the release mask, so set wins on the same bank.
        if (found) begin
            ready_nx[win]       = 1'b1;
            mstate_nx[win_bank] = MEM_LOAD;
            din_nx              = bus.req_data[win*MAT_W +: MAT_W];
            full_nx[win_bank]   = 1'b1;
            cur_nx              = win;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: the data register is reset too, because mem_din must read zero after reset.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state    <= ARB_IDLE;
            ready_q  <= '0;
            mstate_q <= '0;
            din_q    <= '0;
            full_q   <= '0;
            cur_q    <= '0;
        end else begin
            state    <= state_nx;
            ready_q  <= ready_nx;
            mstate_q <= mstate_nx;
            din_q    <= din_nx;
            full_q   <= full_nx;
            cur_q    <= cur_nx;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.mem_state = mstate_q;
    assign bus.mem_din   = din_q;
    assign bus.bank_full = full_q;
    assign bus.busy      = (state == ARB_LOAD);

endmodule

// File: tb/tb_matrix_load_arbiter.sv
// Self-checking bench for matrix_load_arbiter: directed vector table, corner sequences, randomized model run.
module tb_matrix_load_arbiter;

    localparam int NR = 4;
    localparam int NB = 4;
    localparam int W  = 256;
    localparam int BW = 2;

    localparam logic [W-1:0] D0 = {32{8'hA5}};
    localparam logic [W-1:0] D1 = {32{8'h11}};
    localparam logic [W-1:0] D2 = {32{8'h22}};
    localparam logic [W-1:0] D3 = {32{8'h33}};

`ifdef MATRIX_ARB_FIXED_PRIO_EN
    localparam int FIRST  = 1;
    localparam int SECOND = 3;
`else
    localparam int FIRST  = 3;
    localparam int SECOND = 1;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    matrix_load_arbiter_if #(.NUM_REQ(NR), .NUM_BANK(NB), .MAT_W(W)) bus ();

    matrix_load_arbiter #(.NUM_REQ(NR), .NUM_BANK(NB), .MAT_W(W)) dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] ready, input logic [3:0] mstate,
                             input logic [W-1:0] din, input logic [3:0] full, input logic busy);
        check({tag, "_ready"}, W'(bus.req_ready), W'(ready));
        check({tag, "_mstate"}, W'(bus.mem_state), W'(mstate));
        check({tag, "_din"}, bus.mem_din, din);
        check({tag, "_full"}, W'(bus.bank_full), W'(full));
        check({tag, "_busy"}, W'(bus.busy), W'(busy));
    endtask

    // Reference model: the arbitration rules evaluated once per clock edge.
    logic [3:0]   m_ready, m_mstate, m_full;
    logic [W-1:0] m_din;
    logic         m_busy;
    int           m_cur, m_ptr;

    task automatic model_step();
        logic [3:0] eligible, nf;
        int win, idx;
        logic [1:0] b;
        if (!rst) begin
            m_ready = '0; m_mstate = '0; m_din = '0; m_full = '0;
            m_busy = 1'b0; m_cur = 0; m_ptr = 0;
        end else begin
            for (int i = 0; i < NR; i++)
                eligible[i] = bus.req_valid[i] && !m_full[bus.req_bank[i*BW +: BW]]
                              && !(m_busy && m_cur == i);
            win = -1;
            for (int k = 0; k < NR; k++) begin
`ifdef MATRIX_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (m_ptr + k) % NR;
`endif
                if (win < 0 && eligible[idx]) win = idx;
            end
            nf = m_full & ~bus.bank_release;
            if (win >= 0) begin
                b        = bus.req_bank[win*BW +: BW];
                m_ready  = 4'b0001 << win;
                m_mstate = 4'b0001 << b;
                m_din    = bus.req_data[win*W +: W];
                m_busy   = 1'b1;
                m_cur    = win;
                nf[b]    = 1'b1;
                m_ptr    = (win + 1) % NR;
            end else begin
                m_ready  = '0;
                m_mstate = '0;
                m_busy   = 1'b0;
            end
            m_full = nf;
        end
    endtask

    typedef struct {
        logic         rst;
        logic [3:0]   valid;
        logic [7:0]   bank;
        logic [3:0]   rel;
        logic [3:0]   ready;
        logic [3:0]   mstate;
        logic [W-1:0] din;
        logic [3:0]   full;
        logic         busy;
    } vec_t;

    vec_t         vecs [17];
    logic [1:0]   pb   [NR];
    logic [W-1:0] pd   [NR];
    logic [3:0]   want;

    initial begin
        // single load, release, reset
        vecs[0]  = '{1'b1, 4'b0001, 8'h02, 4'b0000, 4'b0001, 4'b0100, D0, 4'b0100, 1'b1};
        vecs[1]  = '{1'b1, 4'b0000, 8'h02, 4'b0000, 4'b0000, 4'b0000, D0, 4'b0100, 1'b0};
        vecs[2]  = '{1'b1, 4'b0000, 8'h02, 4'b0100, 4'b0000, 4'b0000, D0, 4'b0000, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 8'h02, 4'b0000, 4'b0000, 4'b0000, '0, 4'b0000, 1'b0};
        // fairness: four requesters to four banks from pointer 0
        vecs[4]  = '{1'b1, 4'b1111, 8'hE4, 4'b0000, 4'b0001, 4'b0001, D0, 4'b0001, 1'b1};
        vecs[5]  = '{1'b1, 4'b1110, 8'hE4, 4'b0000, 4'b0010, 4'b0010, D1, 4'b0011, 1'b1};
        vecs[6]  = '{1'b1, 4'b1100, 8'hE4, 4'b0000, 4'b0100, 4'b0100, D2, 4'b0111, 1'b1};
        vecs[7]  = '{1'b1, 4'b1000, 8'hE4, 4'b0000, 4'b1000, 4'b1000, D3, 4'b1111, 1'b1};
        vecs[8]  = '{1'b1, 4'b0000, 8'hE4, 4'b0000, 4'b0000, 4'b0000, D3, 4'b1111, 1'b0};
        // full-bank blocking: req2 to full bank 1
        vecs[9]  = '{1'b1, 4'b0100, 8'h10, 4'b0000, 4'b0000, 4'b0000, D3, 4'b1111, 1'b0};
        vecs[10] = '{1'b1, 4'b0100, 8'h10, 4'b0000, 4'b0000, 4'b0000, D3, 4'b1111, 1'b0};
        vecs[11] = '{1'b1, 4'b0100, 8'h10, 4'b0010, 4'b0000, 4'b0000, D3, 4'b1101, 1'b0};
        vecs[12] = '{1'b1, 4'b0100, 8'h10, 4'b0000, 4'b0100, 4'b0010, D2, 4'b1111, 1'b1};
        vecs[13] = '{1'b1, 4'b0000, 8'h10, 4'b0000, 4'b0000, 4'b0000, D2, 4'b1111, 1'b0};
        // release and set of bank 0 in the same cycle
        vecs[14] = '{1'b1, 4'b0000, 8'h00, 4'b1111, 4'b0000, 4'b0000, D2, 4'b0000, 1'b0};
        vecs[15] = '{1'b1, 4'b0001, 8'h00, 4'b0001, 4'b0001, 4'b0001, D0, 4'b0001, 1'b1};
        vecs[16] = '{1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, D0, 4'b0001, 1'b0};

        rst = 1'b0;
        bus.req_valid    = '0;
        bus.req_bank     = '0;
        bus.req_data     = {D3, D2, D1, D0};
        bus.bank_release = '0;
        tick();
        tick();
        check_all("reset", 4'b0000, 4'b0000, '0, 4'b0000, 1'b0);

        for (int i = 0; i < 17; i++) begin
            rst              = vecs[i].rst;
            bus.req_valid    = vecs[i].valid;
            bus.req_bank     = vecs[i].bank;
            bus.bank_release = vecs[i].rel;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].ready, vecs[i].mstate, vecs[i].din,
                      vecs[i].full, vecs[i].busy);
        end

        // Same-bank collision with the pointer parked at 2.
        bus.req_valid = '0; bus.bank_release = 4'b1111;
        tick();
        check("col_clear_full", W'(bus.bank_full), W'(4'b0000));
        bus.req_valid = 4'b0010; bus.req_bank = 8'h0C; bus.bank_release = '0;
        tick();
        check("col_setup_ready", W'(bus.req_ready), W'(4'b0010));
        bus.req_valid = '0; bus.bank_release = 4'b1000;
        tick();
        check("col_setup_full", W'(bus.bank_full), W'(4'b0000));
        bus.req_valid = 4'b1010; bus.req_bank = 8'h00; bus.bank_release = '0;
        tick();
        check_all("col_win", 4'b0001 << FIRST, 4'b0001, (FIRST == 3) ? D3 : D1, 4'b0001, 1'b1);
        bus.req_valid = 4'b0001 << SECOND;
        tick();
        check_all("col_wait0", 4'b0000, 4'b0000, (FIRST == 3) ? D3 : D1, 4'b0001, 1'b0);
        tick();
        check("col_wait1_ready", W'(bus.req_ready), W'(4'b0000));
        bus.bank_release = 4'b0001;
        tick();
        check("col_rel_ready", W'(bus.req_ready), W'(4'b0000));
        check("col_rel_full", W'(bus.bank_full), W'(4'b0000));
        bus.bank_release = '0;
        tick();
        check_all("col_lose", 4'b0001 << SECOND, 4'b0001, (SECOND == 3) ? D3 : D1, 4'b0001, 1'b1);
        bus.req_valid = '0;
        tick();

        // Reset while a load is in flight.
        bus.req_valid = 4'b0001; bus.req_bank = 8'h02;
        tick();
        check_all("rml_load", 4'b0001, 4'b0100, D0, 4'b0101, 1'b1);
        rst = 1'b0;
        tick();
        check_all("rml_reset", 4'b0000, 4'b0000, '0, 4'b0000, 1'b0);
        rst = 1'b1; bus.req_valid = '0;
        tick();
        check_all("rml_after", 4'b0000, 4'b0000, '0, 4'b0000, 1'b0);

        // Randomized traffic against the reference model.
        rst = 1'b0; bus.req_valid = '0; bus.bank_release = '0;
        model_step();
        tick();
        check_all("rnd_rst", m_ready, m_mstate, m_din, m_full, m_busy);
        rst  = 1'b1;
        want = '0;
        for (int i = 0; i < NR; i++) begin
            pb[i] = 2'($urandom_range(0, 3));
            pd[i] = {8{$urandom}};
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (m_ready[i]) begin
                    pb[i]   = 2'($urandom_range(0, 3));
                    pd[i]   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                    want[i] = 1'($urandom_range(0, 1));
                end else if (!want[i]) begin
                    want[i] = ($urandom_range(0, 2) == 0);
                end else if ($urandom_range(0, 7) == 0) begin
                    want[i] = 1'b0;
                end
                bus.req_bank[i*BW +: BW] = pb[i];
                bus.req_data[i*W +: W]   = pd[i];
            end
            bus.req_valid    = want;
            bus.bank_release = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            rst              = ($urandom_range(0, 99) != 0);
            model_step();
            tick();
            check_all($sformatf("rnd%0d", cyc), m_ready, m_mstate, m_din, m_full, m_busy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_load_arbiter.md
Name: matrix_load_arbiter

Overview:
- Shares a bank of NUM_BANK 256-bit matrix registers among NUM_REQ requesters (host loader, result writeback, etc.).
- Arbitrates load requests round-robin and drives one shared Min bus plus one per-bank latch/load select.
- Tracks a per-bank full flag, so a bank is not overwritten until its consumer releases it.
- Sits between the requesters and the matrix memory instances in the matrix calculator.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NUM_BANK, 4, number of matrix register banks (power of two, 2..8)
- MAT_W, 256, matrix width in bits

Ports:
- CLK  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester load request
- req_bank  input  NUM_REQ*log2(NUM_BANK)  target bank; slice i belongs to requester i
- req_data  input  NUM_REQ*MAT_W  matrix to load; slice i belongs to requester i
- req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester
- mem_state  output  NUM_BANK  per-bank memory_state: 0 = latch, 1 = load
- mem_din  output  MAT_W  shared Min bus to all banks
- bank_full  output  NUM_BANK  bank holds unconsumed data
- bank_release  input  NUM_BANK  consumer pulse; clears bank_full
- busy  output  1  high while in LOAD state

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; req_ready=0, mem_state=0, mem_din=0, bank_full=0, busy=0; RR pointer=0. Reset mid-LOAD aborts the load, and no ready pulse is issued.
- Eligibility: requester i is eligible if req_valid[i]=1, bank_full[req_bank_i]=0, and i is not the requester currently in LOAD.
- Arbitration (combinational, registered): pick the first eligible requester at or after the RR pointer, wrapping modulo NUM_REQ. On grant, the pointer becomes winner+1 (wraps).
- Only one grant per cycle. If two eligible requesters target the same bank, only the arbitration winner proceeds; the loser becomes ineligible once bank_full is set.
- FSM:
  - IDLE: if any requester is eligible, register winner, bank, and data; set bank_full[bank]=1; go to LOAD. Otherwise stay in IDLE.
  - LOAD: mem_state[bank]=1 for exactly this cycle, mem_din=registered data, req_ready[winner]=1, busy=1. Arbitrate again in the same cycle: go to LOAD if anything is eligible (back-to-back loads, one per cycle), else go to IDLE.
- Latency: request seen at edge N; mem_state/req_ready are high in cycle N+1; the matrix register captures at edge N+2.
- Requester contract: req_bank and req_data must be held stable until req_ready. Deasserting req_valid before ready is allowed only while not granted; after a grant, the load completes from the registered copy.
- Outputs are all registered. mem_state is zero-hot or one-hot. mem_din holds its last value when idle.
- bank_full: set on grant, cleared by bank_release[b].
  - A release in the same cycle as a set for the same bank: set wins.
  - A release of an empty bank is a no-op.
- An out-of-range req_bank cannot occur, since the width is exact.

Optional Feature:
- Macro MATRIX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest requester index wins; RR pointer logic is removed. Back-to-back loads and the masking of the in-flight requester are unchanged.
- Undefined: round-robin as above.

Decomposition:
- Shared package matrix_pkg:
  - constants MAT_W=256, MEM_LATCH=0, MEM_LOAD=1
  - arb_state_t enum {ARB_IDLE, ARB_LOAD}
  - function clog2 for bank index width
- One natural sub-module: rr_picker (combinational). Inputs are the eligible vector and pointer; outputs are winner index and found flag. It is shared by both arbitration modes, with pointer forced to 0 under MATRIX_ARB_FIXED_PRIO_EN.

Test Plan:
- Single load: req0 valid, bank 2, data 0xA5..A5. Required: mem_state=4'b0100, mem_din=0xA5..A5, and req_ready=4'b0001 in the next cycle only; bank_full=4'b0100.
- Round-robin fairness: req0–req3 all valid to banks 0–3, pointer 0. Required: grants 0,1,2,3 in consecutive LOAD cycles, busy high for 4 cycles; with MATRIX_ARB_FIXED_PRIO_EN, same order.
- Full-bank blocking: bank 1 full, req2 to bank 1. Required: no ready pulse until bank_release=4'b0010, then a grant follows 1 cycle later.
- Same-bank collision: req1 and req3 both to bank 0, pointer 2. Required: req3 wins; req1 waits until bank 0 is released, then loads.
- Release/set same cycle: bank_release[0] pulses in the grant cycle of a new bank-0 load. Required: bank_full[0] stays 1.
- Reset mid-LOAD: reset=0 during LOAD. Required: at the next edge all outputs are 0, no req_ready, and the previously loaded bank is not counted full.
